fifo_fwft: RTL and testbench

Parametrised first-word-fall-through FIFO with occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It succeeds the fixed-depth I/O FIFO on the ANN input/output path and buffers read-in data words between the pad interface and the downstream patch/KD-tree logic. It supports any depth of 2 or more, including non-power-of-two depths, and head data is visible with zero added latency.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_wrap_ptr.sv | 50 +++++
 rtl/fifo_fwft.sv | 142 ++++++++++++++
 tb/tb_fifo_fwft.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the first-word-fall-through FIFO:
//   DEFAULT_DATA_WIDTH  default word width (11 bits)
//   DEFAULT_FIFO_DEPTH  default number of entries
//   fifoParamsLegal()   elaboration-time legality check for depth and
//                       almost-full / almost-empty thresholds
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 11;
    localparam int DEFAULT_FIFO_DEPTH = 8;

    // Depth must be at least 2. Almost-full may sit anywhere from 1 up to
    // the full depth. Almost-empty must stay below the full depth.
    function automatic bit fifoParamsLegal(input int depth,
                                           input int afLevel,
                                           input int aeLevel);
        return (depth >= 2) &&
               (afLevel >= 1) && (afLevel <= depth) &&
               (aeLevel >= 0) && (aeLevel <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// ---------------------------------------------------------------------------
// fifo_wrap_ptr
// Modulo-FIFO_DEPTH pointer. It counts 0..FIFO_DEPTH-1 and then returns to 0,
// so it works for any depth, including non-power-of-two depths.
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-high reset (pointer -> 0)
//   clr  in   synchronous clear (pointer -> 0), wins over inc
//   inc  in   advance pointer by one
//   ptr  out  current pointer value
// ---------------------------------------------------------------------------
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter  int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    output logic [PTR_WIDTH-1:0] ptr
);

    localparam logic [PTR_WIDTH-1:0] LAST = PTR_WIDTH'(FIFO_DEPTH - 1);

    logic [PTR_WIDTH-1:0] ptr_q;
    logic [PTR_WIDTH-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            // Wrap explicitly, because the depth may not be a power of two.
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_fwft.sv
// ---------------------------------------------------------------------------
// fifo_fwft
// First-word-fall-through FIFO with occupancy count, almost-full and
// almost-empty thresholds, and sticky overflow/underflow flags.
// Ports:
//   clk           in   clock
//   rst           in   asynchronous active-high reset
//   din           in   write data
//   enq           in   write request (accepted when full_n)
//   full_n        out  1 = space available
//   dout          out  head-of-queue data, 0 when empty
//   deq           in   pop request (accepted when empty_n)
//   empty_n       out  1 = data available
//   clr           in   synchronous flush, wins over enq/deq
//   count         out  occupancy 0..FIFO_DEPTH
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   overflow      out  sticky, set by enq while full
//   underflow     out  sticky, set by deq while empty
// ---------------------------------------------------------------------------
module fifo_fwft
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter  int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter  int AF_LEVEL    = FIFO_DEPTH - 1,
    parameter  int AE_LEVEL    = 1,
    localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH + 1),
    localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   enq,
    output logic                   full_n,
    output logic [DATA_WIDTH-1:0]  dout,
    input  logic                   deq,
    output logic                   empty_n,
    input  logic                   clr,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow
);

    if (!fifoParamsLegal(FIFO_DEPTH, AF_LEVEL, AE_LEVEL)) begin : gen_param_check
        $error("fifo_fwft: illegal FIFO_DEPTH=%0d / AF_LEVEL=%0d / AE_LEVEL=%0d",
               FIFO_DEPTH, AF_LEVEL, AE_LEVEL);
    end

    localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(FIFO_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] AF_C    = COUNT_WIDTH'(AF_LEVEL);
    localparam logic [COUNT_WIDTH-1:0] AE_C    = COUNT_WIDTH'(AE_LEVEL);

    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   overflow_q;
    logic                   overflow_d;
    logic                   underflow_q;
    logic                   underflow_d;
    logic                   wr_fire;
    logic                   rd_fire;

    // Acceptance uses only registered status, so full+enq+deq pops only and
    // empty+enq+deq writes only.
    assign wr_fire = enq & full_n & ~clr;
    assign rd_fire = deq & empty_n & ~clr;

    fifo_wrap_ptr #(.FIFO_DEPTH(FIFO_DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (wr_fire),
        .ptr (wr_ptr)
    );

    fifo_wrap_ptr #(.FIFO_DEPTH(FIFO_DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (rd_fire),
        .ptr (rd_ptr)
    );

    // The storage is deliberately left unreset, so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr] <= din;
        end
    end

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr) begin
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            case ({wr_fire, rd_fire})
                2'b10:   count_d = count_q + COUNT_WIDTH'(1);
                2'b01:   count_d = count_q - COUNT_WIDTH'(1);
                default: count_d = count_q;
            endcase
            if (enq && !full_n) begin
                overflow_d = 1'b1;
            end
            if (deq && !empty_n) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // All status outputs are decoded from the count register alone, so they
    // cannot glitch on request inputs.
    assign full_n       = (count_q != DEPTH_C);
    assign empty_n      = (count_q != '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign dout         = empty_n ? mem_q[rd_ptr] : '0;

endmodule

// File: tb/tb_fifo_fwft.sv
// ---------------------------------------------------------------------------
// tb_fifo_fwft
// Scoreboard bench for fifo_fwft (depth 5, AF 4, AE 1). The driver keeps a
// queue-level model of occupancy and flags and pushes accepted write data to
// a scoreboard queue. A negedge monitor pops and compares dout on every
// accepted pop.
// ---------------------------------------------------------------------------
module tb_fifo_fwft;

    localparam int DW    = 11;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic [DW-1:0] din;
    logic          enq;
    logic          full_n;
    logic [DW-1:0] dout;
    logic          deq;
    logic          empty_n;
    logic          clr;
    logic [CW-1:0] count;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    int nCompared   = 0;
    int nMismatched = 0;

    int expQ[$];
    int mCount = 0;
    bit mOvf   = 1'b0;
    bit mUnf   = 1'b0;

    fifo_fwft #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .enq          (enq),
        .full_n       (full_n),
        .dout         (dout),
        .deq          (deq),
        .empty_n      (empty_n),
        .clr          (clr),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic compare(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mCount = 0;
        mOvf   = 1'b0;
        mUnf   = 1'b0;
        expQ.delete();
    endtask

    task automatic checkOutput();
        compare("count", int'(count), mCount);
        compare("full_n", int'(full_n), int'(mCount != DEPTH));
        compare("empty_n", int'(empty_n), int'(mCount != 0));
        compare("almost_full", int'(almost_full), int'(mCount >= AF));
        compare("almost_empty", int'(almost_empty), int'(mCount <= AE));
        compare("overflow", int'(overflow), int'(mOvf));
        compare("underflow", int'(underflow), int'(mUnf));
        compare("dout_head", int'(dout), (expQ.size() != 0) ? expQ[0] : 0);
    endtask

    // Drives one cycle of requests, advances the model by the FIFO rules
    // against the pre-edge occupancy, then checks status after the edge.
    task automatic applyStimulus(input bit e, input bit d, input bit c, input int data);
        bit wasFull;
        bit wasEmpty;
        enq = e;
        deq = d;
        clr = c;
        din = DW'(data);
        wasFull  = (mCount == DEPTH);
        wasEmpty = (mCount == 0);
        if (c) begin
            modelReset();
        end else begin
            if (e && wasFull)  mOvf = 1'b1;
            if (d && wasEmpty) mUnf = 1'b1;
            if (e && !wasFull) begin
                expQ.push_back(data & ((1 << DW) - 1));
                mCount++;
            end
            if (d && !wasEmpty) mCount--;
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic asyncResetMidBurst();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 40 + i);
        enq = 1'b1;
        deq = 1'b0;
        clr = 1'b0;
        din = DW'(50);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;
        enq = 1'b0;
        checkOutput();
        applyStimulus(1'b1, 1'b0, 1'b0, 'h33);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
    endtask

    // Monitor: an accepted pop at the coming edge must present the oldest
    // outstanding write on dout.
    always @(negedge clk) begin
        if (!rst && !clr && deq && empty_n) begin
            if (expQ.size() == 0) begin
                compare("monitor_underrun", 1, 0);
            end else begin
                compare("pop_data", int'(dout), expQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        nMismatched++;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        rst = 1'b1;
        enq = 1'b0;
        deq = 1'b0;
        clr = 1'b0;
        din = '0;
        @(posedge clk);
        #1;
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput();

        $display("[TB] fill to full and overflow");
        for (int v = 1; v <= 5; v++) applyStimulus(1'b1, 1'b0, 1'b0, v);
        applyStimulus(1'b1, 1'b0, 1'b0, 6);

        $display("[TB] drain and wrap");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0);
        for (int v = 7; v <= 10; v++) applyStimulus(1'b1, 1'b0, 1'b0, v);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0);

        $display("[TB] simultaneous enq/deq");
        for (int v = 11; v <= 13; v++) applyStimulus(1'b1, 1'b0, 1'b0, v);
        applyStimulus(1'b1, 1'b1, 1'b0, 14);
        applyStimulus(1'b1, 1'b1, 1'b0, 15);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16);
        for (int v = 17; v <= 20; v++) applyStimulus(1'b1, 1'b0, 1'b0, v);
        applyStimulus(1'b1, 1'b1, 1'b0, 21);

        $display("[TB] clr priority");
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 99);
        applyStimulus(1'b1, 1'b0, 1'b0, 'h2A);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);

        $display("[TB] async reset mid-burst");
        asyncResetMidBurst();

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 39) == 0),
                          int'($urandom_range(0, 2047)));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
